// File: rtl/sme_matcher.sv
// sme_matcher: datapath and sequential search engine of the string-matching
// engine. Characters from the byte stream are collected into a string buffer
// (isstr) and a pattern buffer (ispat) while the controller is not in MATCH.
// When the controller enters MATCH, the pattern is searched for in the string.
// The search tries one start position at a time, compares one character per
// cycle, and reports the lowest qualifying start position.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   chardata     ASCII character, sampled when isstr or ispat is high
//   isstr        chardata is a string character (wins over ispat)
//   ispat        chardata is a pattern character
//   ctrlsig      controller state: 00 IDLE, 01 READ, 11 MATCH
//   valid        one-cycle result strobe
//   match        pattern found (held until the next valid)
//   match_index  start index of the core match (held until the next valid)
module sme_matcher #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int IDX_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       chardata,
    input  logic             isstr,
    input  logic             ispat,
    input  logic [1:0]       ctrlsig,
    output logic             valid,
    output logic             match,
    output logic [IDX_W-1:0] match_index
);

    localparam int LEN_W  = $clog2(STR_MAX + 1);
    localparam int PLEN_W = $clog2(PAT_MAX + 1);
    localparam int PIDX_W = $clog2(PAT_MAX);

    localparam logic [LEN_W-1:0]  STR_FULL = LEN_W'(STR_MAX);
    localparam logic [PLEN_W-1:0] PAT_FULL = PLEN_W'(PAT_MAX);

    localparam logic [7:0] CH_CARET  = 8'h5E;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_DOT    = 8'h2E;
    localparam logic [7:0] CH_SPACE  = 8'h20;

    typedef enum logic [1:0] {ST_WAIT, ST_SCAN, ST_REPORT} state_t;

    logic [7:0]        str_mem [STR_MAX];
    logic [7:0]        pat_mem [PAT_MAX];
    logic [LEN_W-1:0]  str_len;
    logic [PLEN_W-1:0] pat_len;
    logic              isstr_d;
    logic              ispat_d;
    logic              loading;

    state_t            state;
    logic [LEN_W-1:0]  s;
    logic [PLEN_W-1:0] j;

    // Lengths stop at buffer depth; extra characters are dropped.
    function automatic logic [LEN_W-1:0] sat_inc_str(input logic [LEN_W-1:0] v);
        return (v == STR_FULL) ? v : v + LEN_W'(1);
    endfunction

    function automatic logic [PLEN_W-1:0] sat_inc_pat(input logic [PLEN_W-1:0] v);
        return (v == PAT_FULL) ? v : v + PLEN_W'(1);
    endfunction

    assign loading = (ctrlsig != 2'b11);

    // Length/edge-detect control. A rising strobe restarts its buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            str_len <= '0;
            pat_len <= '0;
            isstr_d <= 1'b0;
            ispat_d <= 1'b0;
        end else begin
            isstr_d <= isstr;
            ispat_d <= ispat;
            if (loading) begin
                if (isstr)
                    str_len <= isstr_d ? sat_inc_str(str_len) : LEN_W'(1);
                else if (ispat)
                    pat_len <= ispat_d ? sat_inc_pat(pat_len) : PLEN_W'(1);
            end
        end
    end

    // Buffer storage carries no reset; its contents only matter below the lengths.
    always_ff @(posedge clk) begin
        if (loading) begin
            if (isstr) begin
                if (!isstr_d)
                    str_mem[0] <= chardata;
                else if (str_len < STR_FULL)
                    str_mem[str_len[IDX_W-1:0]] <= chardata;
            end else if (ispat) begin
                if (!ispat_d)
                    pat_mem[0] <= chardata;
                else if (pat_len < PAT_FULL)
                    pat_mem[pat_len[PIDX_W-1:0]] <= chardata;
            end
        end
    end

    // Anchor decode: '^' only at position 0, '$' only at the last position.
    // The core pattern starts after a leading '^' and has length m.
    logic                anc_s;
    logic                anc_e;
    logic [PLEN_W-1:0]   m;
    logic [PIDX_W-1:0]   last_idx;
    logic [LEN_W:0]      s_plus_m;
    logic                past_end;
    logic [IDX_W-1:0]    str_idx;
    logic [PIDX_W-1:0]   pat_idx;
    logic                char_ok;
    logic                pre_ok;
    logic                post_ok;
    logic                anchors_ok;

    assign last_idx = PIDX_W'(pat_len - PLEN_W'(1));
    assign anc_s    = (pat_len != '0) && (pat_mem[0] == CH_CARET);
    assign anc_e    = (pat_len != '0) && (pat_mem[last_idx] == CH_DOLLAR);
    assign m        = pat_len - PLEN_W'(anc_s) - PLEN_W'(anc_e);

    // Start positions run out once s+m exceeds n; an empty core never matches.
    assign s_plus_m = (LEN_W+1)'(s) + (LEN_W+1)'(m);
    assign past_end = (m == '0) || (s_plus_m > (LEN_W+1)'(str_len));

    assign str_idx  = IDX_W'(s + LEN_W'(j));
    assign pat_idx  = PIDX_W'(PLEN_W'(anc_s) + j);
    assign char_ok  = (pat_mem[pat_idx] == CH_DOT) || (pat_mem[pat_idx] == str_mem[str_idx]);

    // Anchors require a word boundary (buffer edge or space) next to the core.
    assign pre_ok     = (s == '0) || (str_mem[IDX_W'(s - LEN_W'(1))] == CH_SPACE);
    assign post_ok    = (s_plus_m == (LEN_W+1)'(str_len)) || (str_mem[IDX_W'(s_plus_m)] == CH_SPACE);
    assign anchors_ok = (!anc_s || pre_ok) && (!anc_e || post_ok);

    // valid is raised on entry to REPORT so it drops as the FSM returns to
    // WAIT; by then the controller has already left MATCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_WAIT;
            s           <= '0;
            j           <= '0;
            valid       <= 1'b0;
            match       <= 1'b0;
            match_index <= '0;
        end else begin
            case (state)
                ST_WAIT: begin
                    valid <= 1'b0;
                    s     <= '0;
                    j     <= '0;
                    if (ctrlsig == 2'b11)
                        state <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (past_end) begin
                        state       <= ST_REPORT;
                        valid       <= 1'b1;
                        match       <= 1'b0;
                        match_index <= '0;
                    end else if (j < m) begin
                        if (char_ok) begin
                            j <= j + PLEN_W'(1);
                        end else begin
                            s <= s + LEN_W'(1);
                            j <= '0;
                        end
                    end else if (anchors_ok) begin
                        state       <= ST_REPORT;
                        valid       <= 1'b1;
                        match       <= 1'b1;
                        match_index <= IDX_W'(s);
                    end else begin
                        s <= s + LEN_W'(1);
                        j <= '0;
                    end
                end
                ST_REPORT: begin
                    valid <= 1'b0;
                    state <= ST_WAIT;
                end
                default: begin
                    valid <= 1'b0;
                    state <= ST_WAIT;
                end
            endcase
        end
    end

endmodule

// File: doc/sme_matcher.md
# sme_matcher

Datapath and search engine of the string-matching engine. It loads a string (up to 32 chars) and a pattern (up to 8 chars) from the byte stream, then runs a sequential search when the controller FSM enters MATCH. It reports one result per pattern on `valid`/`match`/`match_index`, and that `valid` returns the controller to READ.

## Interface
- `STR_MAX`, 32: string buffer depth (chars)
- `PAT_MAX`, 8: pattern buffer depth (chars)
- `IDX_W`, 5: width of `match_index` (= log2 `STR_MAX`)
- `clk`  in  1: single clock, all state on rising edge
- `rst`  in  1: asynchronous, active-high reset
- `chardata`  in  8: ASCII character, sampled when `isstr` or `ispat` is high
- `isstr`  in  1: `chardata` is a string character
- `ispat`  in  1: `chardata` is a pattern character
- `ctrlsig`  in  2: controller state: 00 IDLE, 01 READ, 11 MATCH
- `valid`  out  1: one-cycle result strobe
- `match`  out  1: pattern found (held until next `valid`)
- `match_index`  out  `IDX_W`: start index of the core match (held until next `valid`)

## Operation
- **Loading**
  - Active whenever `ctrlsig != 11`.
  - A cycle with `isstr=1` while `isstr` was 0 in the previous cycle starts a new string: `str_len` clears to 0, the char is written at 0, and `str_len` becomes 1.
  - Subsequent `isstr` cycles write at `str_len` and increment it.
  - Pattern loading is identical, using `ispat` and `pat_len`.
  - Chars beyond `STR_MAX`/`PAT_MAX` are dropped; the length saturates.
  - A string persists across any number of following patterns.
- **Anchors**
  - `'^'` (0x5E) is an anchor only at pattern position 0.
  - `'$'` (0x24) is an anchor only at position `pat_len-1`.
  - Both anchors are stripped to form the core pattern of length m.
  - `'.'` (0x2E) in the core matches any char.
- **Match condition at start s** (0 ≤ s ≤ n−m, n = `str_len`):
  - every core char equals `str[s+j]` or is `'.'`;
  - if `'^'`: s==0 or `str[s-1]`==0x20;
  - if `'$'`: s+m==n or `str[s+m]`==0x20.
- **Result**: the lowest qualifying s is reported.
  - No match: `match=0`, `match_index=0`.
  - m==0, or m>n: `match=0`, `match_index=0`, with no scan.
- **Search FSM**
  - **WAIT**: go to SCAN when `ctrlsig==11`; clear s=0, j=0.
  - **SCAN**: one comparison per cycle.
    - j<m and `pat[j]` matches `str[s+j]`: j++.
    - j<m mismatch: s++, j=0.
    - j==m: check anchors. Pass: record s and go to REPORT with hit. Fail: s++, j=0.
    - s>n−m at any cycle: go to REPORT with miss.
  - **REPORT**: register `valid=1`, `match`, `match_index`; go to WAIT.
- **Reset** (any time, including mid-scan or mid-load):
  - FSM to WAIT; `str_len`, `pat_len`, s, j cleared.
  - `valid=0`, `match=0`, `match_index=0`.
  - Buffer contents are don't-care.

## Timing
- All outputs are registered.
- `valid` is high for exactly one cycle. The controller sees it while still in MATCH, so `ctrlsig` returns to 01 the next cycle and WAIT does not retrigger.
- Latency from first `ctrlsig==11` cycle to `valid`:
  - 1 (WAIT→SCAN), plus 1 per SCAN cycle, plus 1 (REPORT).
  - A mismatch at depth j costs j+1 cycles; a success costs m+1 cycles.
  - Worst case: ≤ (n−m+1)(m+1)+2 ≤ 300 cycles.
- Load and scan never overlap: `isstr`/`ispat` during `ctrlsig==11` are ignored.
- `isstr` and `ispat` never overlap. If both are high in one cycle, `isstr` wins.
- The last loaded char is available to SCAN in the first MATCH cycle. The controller guarantees at least one READ cycle with both strobes low.

## Test plan
- **Plain match**: string "hello world"; pattern "wor".
  - `valid` pulses once; `match=1`, `match_index=6`; `ctrlsig` returns to 01 the next cycle.
- **Start anchor**: same string.
  - "^wo" → `match=1`, idx 6.
  - "^or" → `match=0`, idx 0.
  - "^he" → `match=1`, idx 0.
- **End anchor and wildcard**:
  - "lo$" → `match=1`, idx 3.
  - "wor$" → `match=0`.
  - "o.w" → `match=1`, idx 4.
  - "^.....$" → `match=1`, idx 0.
- **Reload and persistence**:
  - Three patterns against one string; each pattern is cleared on its `ispat` rise.
  - A new string "aaab" with pattern "ab" → idx 2.
  - A 40-char string saturates at 32 chars.
  - A 10-char pattern saturates at 8 chars.
- **Degenerate cases**: each gives `match=0` with `valid` 2 cycles after MATCH entry.
  - Pattern "^$" (m==0).
  - Pattern "abcd" on string "abc".
- **Reset mid-scan**:
  - Assert `rst` 5 cycles into SCAN: `valid`/`match`/`match_index` go to 0 immediately.
  - After reload, a fresh search completes correctly.
